lcd_sequencer: RTL and testbench
================================

# lcd_sequencer

Memory-mapped HD44780 character-LCD write sequencer on the PIC16F external peripheral bus. It sits beside the port peripherals in the DE2-115 top level and takes the LCD pins away from software bit-banging. A single core write to the command or data register launches a complete, timing-correct E-strobe transfer, followed by the controller's execution wait. Software polls a busy flag or takes a one-cycle done strobe on an interrupt-strobe line.

## Interface
- `CMD_ADDR`, default 9'h09D: peripheral address of the command register (RS=0 transfer).
- `DAT_ADDR`, default 9'h09E: peripheral address of the data register (RS=1 transfer).
- `STAT_ADDR`, default 9'h09F: peripheral address of the status register.
- `SETUP_CYCLES`, default 3: cycles RS and data are stable before E rises. Minimum 1.
- `PULSE_CYCLES`, default 25: E-high width in cycles. Minimum 1.
- `HOLD_CYCLES`, default 3: cycles E stays low with data held after E falls. Minimum 1.
- `EXEC_CYCLES`, default 2000: execution wait for normal instructions (37 µs at 50 MHz, with margin).
- `LONG_EXEC_CYCLES`, default 80000: execution wait for clear and home instructions.

- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset; connect to `rst_peripherals`.
- `addr` in 9: peripheral bus address.
- `wr_en` in 1: peripheral bus write strobe.
- `data_in` in 8: peripheral bus write data.
- `data_out` out 8: combinational read data; 0 for unmapped addresses.
- `done_strobe` out 1: one-cycle pulse when a transfer fully completes; goes to an interrupt-strobe bit.
- `lcd_data` out 8: LCD DB7..DB0.
- `lcd_rs` out 1: register select.
- `lcd_rw` out 1: read/write select; constant 0, since the block only writes.
- `lcd_e` out 1: enable strobe.

## Operation
- FSM states: IDLE → SETUP → PULSE → HOLD → WAIT → IDLE.
- The block accepts a write only in IDLE, when `addr` is CMD_ADDR or DAT_ADDR and `wr_en`=1.
- On accept, the block latches the byte, sets RS (0 for CMD, 1 for DAT), loads the timer with SETUP_CYCLES and enters SETUP.
- SETUP: E=0, RS and data driven. Exit when the timer expires.
- PULSE: E=1 for PULSE_CYCLES.
- HOLD: E=0 for HOLD_CYCLES; data and RS are held.
- WAIT: E=0. Timer is loaded with LONG_EXEC_CYCLES if RS=0 and the byte is 8'h01, 8'h02 or 8'h03; otherwise EXEC_CYCLES. On expiry, go to IDLE and pulse `done_strobe`.
- `lcd_data` and `lcd_rs` keep their last values while IDLE.
- Status register reads as {6'b0, overrun, busy}. `busy` = (state != IDLE).
- Write to CMD/DAT while busy: the write is dropped, sticky `overrun` sets, and the transfer in flight is unaffected.
- Any write to STAT_ADDR clears `overrun`. If an overrun-causing write and a STAT write coincide, set wins (they cannot share an address, so this only matters for future multi-port use).
- Reads of CMD_ADDR/DAT_ADDR return the last accepted byte.
- Timer width is $clog2(LONG_EXEC_CYCLES+1). Every phase lasts exactly its parameter value in cycles.

## Timing
- Reset values: `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0, `done_strobe`=0, busy=0, overrun=0, latched byte=0, state IDLE.
- Accepting write in cycle n: busy=1, RS and data valid from n+1.
- E rises at n+1+SETUP_CYCLES and falls PULSE_CYCLES later.
- `done_strobe` is high in the first IDLE cycle, n+1+S+P+H+W. In that same cycle, busy=0 and a new write is accepted.
- `rst` asserted mid-transfer: the next edge forces all reset values, so E drops within one cycle and no `done_strobe` is produced.

## Configuration
- `LCD_SEQ_NIBBLE_EN` defined: 4-bit bus mode. Each byte goes as two full SETUP/PULSE/HOLD sequences: high nibble, then low nibble, on `lcd_data[7:4]`, with `lcd_data[3:0]`=0. A NIBBLE_GAP state of HOLD_CYCLES separates the two sequences. WAIT follows only the second nibble. Total transfer length is 2(S+P+H)+W cycles (the gap reuses HOLD).
- Macro undefined: 8-bit single transfer exactly as above; no nibble state exists.

## Structure
- `lcd_seq_pkg` holds the state enum, the default address constants, and the function `is_long_cmd(rs, byte)`.
- One sub-module, `lcd_seq_timer`: loadable down-counter with `load`, `load_val` and a `expired` output. The FSM uses it for every phase.

## Test plan
Bench parameters: S=2, P=4, H=2, W=10, LW=50.
- Write 8'h38 to CMD at cycle n → RS=0, data=8'h38 at n+1; E high over n+3..n+6; `done_strobe` at n+19.
- Write 8'h41 to DAT → RS=1; STAT reads 8'h01 during the transfer and 8'h00 after `done_strobe`.
- Write 8'h01 to CMD → `done_strobe` at n+59 (long wait).
- Write to DAT at n+5 during a transfer → byte dropped, STAT reads 8'h03. Write to STAT → 8'h01, then 8'h00 after completion.
- Assert `rst` while E=1 → E=0, busy=0, no strobe.
- Back-to-back: write in the `done_strobe` cycle is accepted. With `LCD_SEQ_NIBBLE_EN`, 8'hA5 produces E pulses carrying 4'hA then 4'h5 on [7:4], with `done_strobe` at n+27.

Source files
------------

// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg: shared types and helpers for the HD44780 write sequencer.
// Optional feature macro: LCD_SEQ_NIBBLE_EN (adds the NIBBLE_GAP state).
package lcd_seq_pkg;

   localparam logic [8:0] CMD_ADDR_DEFAULT  = 9'h09D;
   localparam logic [8:0] DAT_ADDR_DEFAULT  = 9'h09E;
   localparam logic [8:0] STAT_ADDR_DEFAULT = 9'h09F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT
`ifdef LCD_SEQ_NIBBLE_EN
      , ST_NIBBLE_GAP
`endif
   } state_t;

   // Clear display (01) and return home (02/03) need the long execution wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
      return !rs && (b == 8'h01 || b == 8'h02 || b == 8'h03);
   endfunction

endpackage

// File: rtl/lcd_sequencer_if.sv
// lcd_sequencer_if: PIC16F external peripheral bus (write strobe + read mux).
interface lcd_sequencer_if;
   logic [8:0] addr;
   logic       wr_en;
   logic [7:0] data_in;
   logic [7:0] data_out;

   modport master (output addr, output wr_en, output data_in, input data_out);
   modport slave  (input addr, input wr_en, input data_in, output data_out);
endinterface

// File: rtl/lcd_seq_timer.sv
// lcd_seq_timer: loadable down-counter. Loading N makes 'expired' rise in the
// N-th cycle after the load edge, so a phase loaded with N lasts exactly N cycles.
module lcd_seq_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             expired
);

   logic [WIDTH-1:0] count_reg;

   // Count down to zero and park there until the next load.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val - WIDTH'(1);
      end else if (count_reg != '0) begin
         count_reg <= count_reg - WIDTH'(1);
      end
   end

   assign expired = (count_reg == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// lcd_sequencer: memory-mapped HD44780 write sequencer. One bus write to the
// command or data register runs SETUP/PULSE/HOLD/WAIT and ends with done_strobe.
// Optional feature macro: LCD_SEQ_NIBBLE_EN (4-bit bus, two strobes per byte).
module lcd_sequencer
   import lcd_seq_pkg::*;
#(
   parameter logic [8:0] CMD_ADDR         = CMD_ADDR_DEFAULT,
   parameter logic [8:0] DAT_ADDR         = DAT_ADDR_DEFAULT,
   parameter logic [8:0] STAT_ADDR        = STAT_ADDR_DEFAULT,
   parameter int         SETUP_CYCLES     = 3,
   parameter int         PULSE_CYCLES     = 25,
   parameter int         HOLD_CYCLES      = 3,
   parameter int         EXEC_CYCLES      = 2000,
   parameter int         LONG_EXEC_CYCLES = 80000
) (
   input  logic             clk,
   input  logic             rst,
   lcd_sequencer_if.slave   bus,
   output logic             done_strobe,
   output logic [7:0]       lcd_data,
   output logic             lcd_rs,
   output logic             lcd_rw,
   output logic             lcd_e
);

   localparam int TW = $clog2(LONG_EXEC_CYCLES + 1);

   state_t        state_reg;
   logic [7:0]    byte_reg;
   logic [7:0]    lcd_data_reg;
   logic          lcd_rs_reg;
   logic          lcd_e_reg;
   logic          done_reg;
   logic          overrun_reg;
`ifdef LCD_SEQ_NIBBLE_EN
   logic          second_reg;
`endif

   logic          cmd_hit, dat_hit, stat_hit, busy, accept;
   logic          timer_load, timer_expired;
   logic [TW-1:0] timer_val;

   assign cmd_hit  = bus.wr_en && (bus.addr == CMD_ADDR);
   assign dat_hit  = bus.wr_en && (bus.addr == DAT_ADDR);
   assign stat_hit = bus.wr_en && (bus.addr == STAT_ADDR);
   assign busy     = (state_reg != ST_IDLE);
   assign accept   = !busy && (cmd_hit || dat_hit);

   lcd_seq_timer #(.WIDTH(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_val),
      .expired  (timer_expired)
   );

   // Reload the timer with the length of the phase being entered.
   always_comb begin
      timer_load = 1'b0;
      timer_val  = TW'(SETUP_CYCLES);
      case (state_reg)
         ST_IDLE: begin
            timer_load = accept;
            timer_val  = TW'(SETUP_CYCLES);
         end
         ST_SETUP: begin
            timer_load = timer_expired;
            timer_val  = TW'(PULSE_CYCLES);
         end
         ST_PULSE: begin
            timer_load = timer_expired;
            timer_val  = TW'(HOLD_CYCLES);
         end
         ST_HOLD: begin
            timer_load = timer_expired;
            timer_val  = is_long_cmd(lcd_rs_reg, byte_reg) ? TW'(LONG_EXEC_CYCLES)
                                                           : TW'(EXEC_CYCLES);
         end
`ifdef LCD_SEQ_NIBBLE_EN
         ST_NIBBLE_GAP: begin
            timer_load = timer_expired;
            timer_val  = TW'(SETUP_CYCLES);
         end
`endif
         default: begin
            timer_load = 1'b0;
         end
      endcase
   end

   // Transfer FSM with registered LCD pins, done strobe and sticky overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         byte_reg     <= 8'h00;
         lcd_data_reg <= 8'h00;
         lcd_rs_reg   <= 1'b0;
         lcd_e_reg    <= 1'b0;
         done_reg     <= 1'b0;
         overrun_reg  <= 1'b0;
`ifdef LCD_SEQ_NIBBLE_EN
         second_reg   <= 1'b0;
`endif
      end else begin
         done_reg <= 1'b0;
         if (busy && (cmd_hit || dat_hit)) begin
            overrun_reg <= 1'b1;
         end else if (stat_hit) begin
            overrun_reg <= 1'b0;
         end
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  byte_reg   <= bus.data_in;
                  lcd_rs_reg <= dat_hit;
`ifdef LCD_SEQ_NIBBLE_EN
                  lcd_data_reg <= {bus.data_in[7:4], 4'h0};
                  second_reg   <= 1'b0;
`else
                  lcd_data_reg <= bus.data_in;
`endif
                  state_reg  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (timer_expired) begin
                  lcd_e_reg <= 1'b1;
                  state_reg <= ST_PULSE;
               end
            end
            ST_PULSE: begin
               if (timer_expired) begin
                  lcd_e_reg <= 1'b0;
`ifdef LCD_SEQ_NIBBLE_EN
                  state_reg <= second_reg ? ST_HOLD : ST_NIBBLE_GAP;
`else
                  state_reg <= ST_HOLD;
`endif
               end
            end
            ST_HOLD: begin
               if (timer_expired) begin
                  state_reg <= ST_WAIT;
               end
            end
`ifdef LCD_SEQ_NIBBLE_EN
            ST_NIBBLE_GAP: begin
               if (timer_expired) begin
                  second_reg   <= 1'b1;
                  lcd_data_reg <= {byte_reg[3:0], 4'h0};
                  state_reg    <= ST_SETUP;
               end
            end
`endif
            ST_WAIT: begin
               if (timer_expired) begin
                  done_reg  <= 1'b1;
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Read mux: last accepted byte on CMD/DAT, {overrun, busy} on STAT.
   always_comb begin
      bus.data_out = 8'h00;
      if (bus.addr == CMD_ADDR || bus.addr == DAT_ADDR) begin
         bus.data_out = byte_reg;
      end else if (bus.addr == STAT_ADDR) begin
         bus.data_out = {6'b0, overrun_reg, busy};
      end
   end

   assign done_strobe = done_reg;
   assign lcd_data    = lcd_data_reg;
   assign lcd_rs      = lcd_rs_reg;
   assign lcd_e       = lcd_e_reg;
   assign lcd_rw      = 1'b0;

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer: randomized scoreboard bench for lcd_sequencer.
// Honours LCD_SEQ_NIBBLE_EN when the bundle is built with it.
module tb_lcd_sequencer;
   import lcd_seq_pkg::*;

   localparam int S = 2, P = 4, H = 2, W = 10, LW = 50;
   localparam logic [8:0] CMD = 9'h09D, DAT = 9'h09E, STAT = 9'h09F;
`ifdef LCD_SEQ_NIBBLE_EN
   localparam int NP = 2;
`else
   localparam int NP = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lcd_sequencer_if bus ();
   logic       done_strobe, lcd_rs, lcd_rw, lcd_e;
   logic [7:0] lcd_data;

   lcd_sequencer #(
      .SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H),
      .EXEC_CYCLES(W), .LONG_EXEC_CYCLES(LW)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .done_strobe(done_strobe),
      .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
   );

   typedef struct {
      logic [7:0] b;
      logic       rs;
      int         acc;
      int         done;
   } txn_t;

   txn_t       sb[$];
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   int         free_cyc = 0;
   logic       ov_m = 1'b0;
   logic [7:0] last_m = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, req);
      end
   endtask

   // Transfer length from the rules: phases plus exec wait, doubled strobes in 4-bit mode.
   function automatic int total_len(input logic rs, input logic [7:0] b);
      int w;
      w = (!rs && b >= 8'd1 && b <= 8'd3) ? LW : W;
      return NP * (S + P + H) + w;
   endfunction

   function automatic logic [7:0] pulse_byte(input logic [7:0] b, input int idx);
`ifdef LCD_SEQ_NIBBLE_EN
      logic [3:0] nib;
      nib = (idx == 0) ? b[7:4] : b[3:0];
      return {nib, 4'h0};
`else
      return (idx == 0) ? b : 8'h00;
`endif
   endfunction

   // Monitor: checks each E strobe and each done_strobe against the scoreboard front.
   int   rise_cyc = 0;
   int   pulse_idx = 0;
   logic e_prev = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         e_prev    = 1'b0;
         pulse_idx = 0;
      end else begin
         if (lcd_e && !e_prev) begin
            if (sb.size() == 0) begin
               chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
               chk("e_rise_cycle", cyc, sb[0].acc + 1 + S + pulse_idx * (S + P + H));
               chk("pulse_data", lcd_data, pulse_byte(sb[0].b, pulse_idx));
               chk("pulse_rs", lcd_rs, sb[0].rs);
               pulse_idx++;
            end
            rise_cyc = cyc;
         end
         if (!lcd_e && e_prev) chk("e_width", cyc - rise_cyc, P);
         if (done_strobe) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               chk("done_cycle", cyc, sb[0].done);
               chk("pulse_count", pulse_idx, NP);
               void'(sb.pop_front());
               pulse_idx = 0;
            end
         end
         e_prev = lcd_e;
      end
   end

   // Issue one bus write; the model decides accept/drop and queues the expectation.
   task automatic bus_write(input logic [8:0] a, input logic [7:0] d);
      txn_t t;
      logic acc, ov_set, ov_clr;
      acc = 1'b0; ov_set = 1'b0; ov_clr = 1'b0;
      @(negedge clk);
      bus.addr = a; bus.data_in = d; bus.wr_en = 1'b1;
      if (a == CMD || a == DAT) begin
         if (cyc >= free_cyc) begin
            acc    = 1'b1;
            t.b    = d;
            t.rs   = (a == DAT);
            t.acc  = cyc;
            t.done = cyc + 1 + total_len(t.rs, d);
            sb.push_back(t);
            free_cyc = t.done;
            last_m   = d;
         end else begin
            ov_set = 1'b1;
         end
      end else if (a == STAT) begin
         ov_clr = 1'b1;
      end
      $display("txn cycle=%0d write addr=%h data=%h %s", cyc, a, d,
               acc ? "accepted" : ((a == STAT) ? "stat" : "dropped"));
      @(negedge clk);
      bus.wr_en = 1'b0; bus.addr = 9'h000;
      if (ov_set) ov_m = 1'b1;
      else if (ov_clr) ov_m = 1'b0;
      if (acc) begin
         chk("start_rs", lcd_rs, t.rs);
         chk("start_data", lcd_data, pulse_byte(d, 0));
      end
   endtask

   task automatic read_chk(input string nm, input logic [8:0] a);
      logic [7:0] req;
      @(negedge clk);
      bus.addr = a;
      #1;
      if (a == STAT) req = {6'b0, ov_m, (cyc < free_cyc)};
      else if (a == CMD || a == DAT) req = last_m;
      else req = 8'h00;
      $display("txn cycle=%0d read addr=%h data=%h", cyc, a, bus.data_out);
      chk(nm, bus.data_out, req);
   endtask

   task automatic wait_done();
      int guard;
      guard = 0;
      while (cyc < free_cyc + 1 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int guard;
      logic [8:0] a;
      logic [7:0] d;
      bus.addr = 9'h000; bus.wr_en = 1'b0; bus.data_in = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_lcd_e", lcd_e, 1'b0);
      chk("rst_lcd_rs", lcd_rs, 1'b0);
      chk("rst_lcd_rw", lcd_rw, 1'b0);
      chk("rst_lcd_data", lcd_data, 8'h00);
      chk("rst_done", done_strobe, 1'b0);
      rst = 1'b0;
      read_chk("rst_stat", STAT);
      read_chk("rst_byte", CMD);

      // Directed: normal command, data byte, long command.
      bus_write(CMD, 8'h38);
      read_chk("stat_busy", STAT);
      wait_done();
      read_chk("stat_idle", STAT);
      bus_write(DAT, 8'h41);
      read_chk("stat_busy_dat", STAT);
      wait_done();
      read_chk("stat_idle_dat", STAT);
      read_chk("read_dat_byte", DAT);
      bus_write(CMD, 8'h01);
      wait_done();

      // Overrun: dropped write at n+5, STAT clear, completion.
      bus_write(CMD, 8'h80);
      repeat (3) @(negedge clk);
      bus_write(DAT, 8'h55);
      read_chk("stat_overrun", STAT);
      bus_write(STAT, 8'h00);
      read_chk("stat_cleared", STAT);
      wait_done();
      read_chk("stat_after_ov", STAT);
      read_chk("byte_kept", DAT);

      // Back-to-back: second write lands in the done_strobe cycle.
      bus_write(CMD, 8'h0C);
      guard = 0;
      while (cyc < free_cyc - 1 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      bus_write(DAT, 8'hA5);
      read_chk("b2b_busy", STAT);
      wait_done();

      // Reset while E is high: E drops, no done_strobe follows.
      bus_write(DAT, 8'h77);
      guard = 0;
      while (!lcd_e && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("e_seen_before_rst", lcd_e, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_e", lcd_e, 1'b0);
      chk("rst_mid_data", lcd_data, 8'h00);
      sb.delete();
      free_cyc = 0; ov_m = 1'b0; last_m = 8'h00;
      rst = 1'b0;
      read_chk("rst_mid_stat", STAT);
      read_chk("rst_mid_byte", CMD);
      repeat (100) @(negedge clk);

      // Randomized traffic, including writes while busy and status traffic.
      for (int i = 0; i < 40; i++) begin
         int op;
         op = $urandom_range(0, 9);
         repeat ($urandom_range(0, 30)) @(negedge clk);
         if (op <= 5) begin
            a = (op[0]) ? DAT : CMD;
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            bus_write(a, d);
         end else if (op == 6) begin
            bus_write(STAT, 8'($urandom));
         end else if (op == 7) begin
            read_chk("rand_byte", CMD);
         end else begin
            read_chk("rand_stat", STAT);
         end
      end
      wait_done();
      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      read_chk("final_stat", STAT);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
